reg_file_2r1w: RTL

Parametrised register file: DEPTH registers of WIDTH bits, one synchronous write port, two registered read ports, and an optional hardwired-zero register. A built-in sequencer clears the whole file on request. It is the successor to the single 8-bit register and serves as the CPU's general-purpose register bank, feeding the ALU operand buses.

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_clear_seq.sv | 67 ++++++
 rtl/reg_file_2r1w.sv | 114 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the 2-read/1-write register file: default geometry
// and the clear-sequencer state encoding.
package reg_file_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer: after a clear_req pulse in idle, walks the address space
// one register per cycle (strobe + address) and reports busy while running.
// clear_req is ignored while a clear is already in progress.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output clr_state_t    state
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  clr_state_t    state_nxt;
  logic [AW-1:0] count;
  logic [AW-1:0] count_nxt;

  // State and counter registers; reset aborts any clear in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state logic: start on request, step the counter, stop after the last register.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      CLR_IDLE: begin
        if (clear_req) begin
          state_nxt = CLR_RUN;
          count_nxt = '0;
        end
      end
      CLR_RUN: begin
        if (count == LAST_ADDR) begin
          state_nxt = CLR_IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      default: begin
        state_nxt = CLR_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // busy comes straight from the state register, so it is glitch-free.
  assign busy     = (state == CLR_RUN);
  assign clr_en   = (state == CLR_RUN);
  assign clr_addr = count;

endmodule

// File: rtl/reg_file_2r1w.sv
// General-purpose register bank: DEPTH x WIDTH array, one synchronous write
// port, two registered read ports, optional hardwired-zero register 0, and a
// built-in sequential clear.
// Optional macro REG_FILE_BYPASS_EN: an accepted write is forwarded to a read
// port addressing the same register at the same edge. Without it the read
// returns the pre-write contents.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_reg,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clear_req,
  output logic             busy
);

  logic [WIDTH-1:0] mem [DEPTH];

  clr_state_t       clr_state;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;

  logic             wr_ok;
  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] rd_val_a;
  logic [WIDTH-1:0] rd_val_b;

  reg_file_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .state     (clr_state)
  );

  // Addresses that do not map to a real, writable register.
  function automatic logic addr_valid(input logic [AW-1:0] addr);
    return (int'(addr) < DEPTH);
  endfunction

  function automatic logic addr_is_zero_reg(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // A write lands only when idle, in range, and not aimed at a hardwired zero.
  assign wr_ok = write_reg && (clr_state == CLR_IDLE) &&
                 addr_valid(wr_addr) && !addr_is_zero_reg(wr_addr);

  // Forwarding is qualified by wr_ok so dropped writes never leak to a read port.
  always_comb begin
    fwd_a = 1'b0;
    fwd_b = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    fwd_a = wr_ok && (wr_addr == rd_addr_a);
    fwd_b = wr_ok && (wr_addr == rd_addr_b);
`endif
  end

  // Read muxes: zero for unmapped or hardwired-zero addresses, else array or forwarded data.
  always_comb begin
    rd_val_a = '0;
    rd_val_b = '0;
    if (addr_valid(rd_addr_a) && !addr_is_zero_reg(rd_addr_a)) begin
      rd_val_a = fwd_a ? wr_data : mem[rd_addr_a];
    end
    if (addr_valid(rd_addr_b) && !addr_is_zero_reg(rd_addr_b)) begin
      rd_val_b = fwd_b ? wr_data : mem[rd_addr_b];
    end
  end

  // Storage array: reset and sequential clear zero it; writes and clears never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (clr_en) begin
        mem[clr_addr] <= '0;
      end
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // Registered read ports; reads continue while a clear is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_val_a;
      rd_data_b <= rd_val_b;
    end
  end

endmodule
